mw_elastic_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage for the vector datapath; successor to the fixed 16x32 MEM/WB register.

---
 rtl/mw_pkg.sv | 37 +++
 rtl/mw_elastic_stage_entry.sv | 41 ++++
 rtl/mw_elastic_stage.sv | 172 +++++++++++++++++
 tb/tb_mw_elastic_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// mw_pkg
// Shared types and defaults for the MEM->WB elastic stage.
//   MW_LANES, MW_DATA_W, MW_REG_AW, MW_CNT_W : default parameter values
//   mw_payload_t   : MEM->WB payload layout for the default configuration
//   mw_state_t     : occupancy of the two-entry stage, encoded {skid, main}
//   payloadWidth() : flat payload width for any LANES/DATA_W/REG_AW
package mw_pkg;

  localparam int MW_LANES  = 16;
  localparam int MW_DATA_W = 32;
  localparam int MW_REG_AW = 4;
  localparam int MW_CNT_W  = 16;

  // Field order matters: the top level packs its own parameter-sized
  // payload with exactly this layout, MSB first.
  typedef struct packed {
    logic [MW_LANES*MW_DATA_W-1:0] alu;
    logic [MW_LANES*MW_DATA_W-1:0] rdata;
    logic                          pcsrc;
    logic                          regwrite;
    logic                          memtoreg;
    logic [MW_REG_AW-1:0]          wa3;
  } mw_payload_t;

  // Encoding is {skidValid, mainValid}; the skid is never valid while
  // main is empty, so 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } mw_state_t;

  function automatic int payloadWidth(input int lanes, input int dataW, input int regAw);
    return 2 * lanes * dataW + 3 + regAw;
  endfunction

endpackage

// File: rtl/mw_elastic_stage_entry.sv
// mw_entry_reg
// One payload register with its valid bit. Used twice by
// mw_elastic_stage: once as the main (output) entry and once as the skid.
//   CLK      : clock, rising edge
//   RST_N    : asynchronous active-low reset, clears valid and data
//   load     : capture loadData and mark the entry valid
//   clear    : mark the entry invalid; wins over load, data is kept
//   loadData : payload to capture
//   valid    : entry holds a live payload
//   data     : stored payload (holds its last value while invalid)
module mw_entry_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] loadData,
  output logic         valid,
  output logic [W-1:0] data
);

  // Valid and data are updated separately so that clearing an entry never
  // disturbs the data it last held; downstream relies on that hold.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
      if (load && !clear) begin
        data <= loadData;
      end
    end
  end

endmodule

// File: rtl/mw_elastic_stage.sv
// mw_elastic_stage
// MEM->WB pipeline stage for the vector datapath with a valid/ready
// handshake and two-entry skid buffering. Full throughput, registered
// in_ready, one cycle latency, strict FIFO order, synchronous flush.
// Optional feature macro: MW_STALL_CNT_EN (adds CNT_W and stall_cnt).
//   CLK, RST_N            : clock (rising edge), async active-low reset
//   FLUSH                 : discard held payloads and any same-cycle input
//   in_valid / in_ready   : MEM-side handshake (in_ready = !skid valid)
//   ALUOutM .. WA3M       : incoming payload
//   out_valid / out_ready : WB-side handshake
//   ALUOutW .. WA3W       : outgoing payload, RegWriteW/PCSrcW gated by out_valid
//   stall_cnt             : saturating count of cycles with out_valid & !out_ready
module mw_elastic_stage
  import mw_pkg::*;
#(
  parameter int LANES  = MW_LANES,
  parameter int DATA_W = MW_DATA_W,
  parameter int REG_AW = MW_REG_AW
`ifdef MW_STALL_CNT_EN
  ,
  parameter int CNT_W  = MW_CNT_W
`endif
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    FLUSH,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] ALUOutM,
  input  logic [LANES*DATA_W-1:0] ReadDataM,
  input  logic                    PCSrcM,
  input  logic                    RegWriteM,
  input  logic                    MemtoRegM,
  input  logic [REG_AW-1:0]       WA3M,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] ALUOutW,
  output logic [LANES*DATA_W-1:0] ReadDataW,
  output logic                    PCSrcW,
  output logic                    RegWriteW,
  output logic                    MemtoRegW,
  output logic [REG_AW-1:0]       WA3W,
`ifdef MW_STALL_CNT_EN
  output logic [CNT_W-1:0]        stall_cnt,
`endif
  input  logic                    out_ready
);

  localparam int PAYLOAD_W = payloadWidth(LANES, DATA_W, REG_AW);

  // Same layout as mw_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [LANES*DATA_W-1:0] alu;
    logic [LANES*DATA_W-1:0] rdata;
    logic                    pcsrc;
    logic                    regwrite;
    logic                    memtoreg;
    logic [REG_AW-1:0]       wa3;
  } payload_t;

  payload_t  inPayload;
  payload_t  mainD;
  payload_t  mainQ;
  payload_t  skidQ;
  logic      mainValid;
  logic      skidValid;
  logic      mainLoad;
  logic      mainClear;
  logic      skidLoad;
  logic      skidClear;
  logic      inXfer;
  logic      outXfer;
  mw_state_t state;

  assign inPayload = '{alu: ALUOutM, rdata: ReadDataM, pcsrc: PCSrcM,
                       regwrite: RegWriteM, memtoreg: MemtoRegM, wa3: WA3M};

  // in_ready comes straight from the skid valid flop, so it is registered
  // and never depends combinationally on out_ready.
  assign in_ready = ~skidValid;

  // Next-state decode. Occupancy lives in the two valid bits; the enum view
  // just makes the three legal cases readable. Main is always the older
  // payload, so in TWO the skid is promoted into main on an output transfer.
  always_comb begin
    state     = mw_state_t'({skidValid, mainValid});
    inXfer    = in_valid & ~skidValid;
    outXfer   = mainValid & out_ready;
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    skidLoad  = 1'b0;
    skidClear = 1'b0;
    mainD     = inPayload;
    if (FLUSH) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          mainLoad = inXfer;
        end
        ST_ONE: begin
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
          end else if (inXfer) begin
            skidLoad = 1'b1;
          end else if (outXfer) begin
            mainClear = 1'b1;
          end
        end
        ST_TWO: begin
          if (outXfer) begin
            mainLoad  = 1'b1;
            mainD     = skidQ;
            skidClear = 1'b1;
          end
        end
        default: begin
          // Skid valid with main empty cannot happen; promote it so the
          // stage recovers instead of stalling forever.
          mainLoad  = 1'b1;
          mainD     = skidQ;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  mw_entry_reg #(.W(PAYLOAD_W)) mainEntry (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (mainLoad),
    .clear    (mainClear),
    .loadData (mainD),
    .valid    (mainValid),
    .data     (mainQ)
  );

  mw_entry_reg #(.W(PAYLOAD_W)) skidEntry (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (skidLoad),
    .clear    (skidClear),
    .loadData (inPayload),
    .valid    (skidValid),
    .data     (skidQ)
  );

  // Outputs always come from main. Data fields hold while invalid, but the
  // two side-effecting controls must never fire on a stale payload.
  assign out_valid = mainValid;
  assign ALUOutW   = mainQ.alu;
  assign ReadDataW = mainQ.rdata;
  assign MemtoRegW = mainQ.memtoreg;
  assign WA3W      = mainQ.wa3;
  assign RegWriteW = mainValid & mainQ.regwrite;
  assign PCSrcW    = mainValid & mainQ.pcsrc;

`ifdef MW_STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Counts WB backpressure cycles. Saturates rather than wrapping, and only
  // reset clears it so a flush does not hide earlier stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (mainValid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mw_elastic_stage.sv
// tb_mw_elastic_stage
// Self-checking bench for mw_elastic_stage. A table of single-cycle vectors
// covers streaming, backpressure, flush and control gating; hand-written
// sequences cover reset mid-stream and, with MW_STALL_CNT_EN, the stall
// counter (instantiated with CNT_W=4).
module tb_mw_elastic_stage;

  localparam int LANES  = 16;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int NVEC   = 26;

  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic                    FLUSH;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] ALUOutM;
  logic [LANES*DATA_W-1:0] ReadDataM;
  logic                    PCSrcM;
  logic                    RegWriteM;
  logic                    MemtoRegM;
  logic [REG_AW-1:0]       WA3M;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] ALUOutW;
  logic [LANES*DATA_W-1:0] ReadDataW;
  logic                    PCSrcW;
  logic                    RegWriteW;
  logic                    MemtoRegW;
  logic [REG_AW-1:0]       WA3W;
`ifdef MW_STALL_CNT_EN
  logic [3:0]              stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic iv;
    logic orr;
    logic fl;
    int   k;
    logic rw;
    logic pc;
    logic eOv;
    logic eIr;
    int   eK;
    logic eRw;
    logic ePc;
  } vecT;

  vecT vecs [NVEC];

  mw_elastic_stage #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
`ifdef MW_STALL_CNT_EN
    ,
    .CNT_W  (4)
`endif
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (FLUSH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOutM   (ALUOutM),
    .ReadDataM (ReadDataM),
    .PCSrcM    (PCSrcM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .WA3M      (WA3M),
    .out_valid (out_valid),
    .ALUOutW   (ALUOutW),
    .ReadDataW (ReadDataW),
    .PCSrcW    (PCSrcW),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .WA3W      (WA3W),
`ifdef MW_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .out_ready (out_ready)
  );

  // Free-running 100 MHz clock.
  always #5 CLK = ~CLK;

  // Lane i of payload k carries 0x100*k + i.
  function automatic logic [LANES*DATA_W-1:0] makeAlu(input int k);
    logic [LANES*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i*DATA_W +: DATA_W] = DATA_W'(k * 256 + i);
    end
    return v;
  endfunction

  function automatic vecT mkVec(input logic iv, input logic orr, input logic fl,
                                input int k, input logic rw, input logic pc,
                                input logic eOv, input logic eIr, input int eK,
                                input logic eRw, input logic ePc);
    vecT v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.k = k; v.rw = rw; v.pc = pc;
    v.eOv = eOv; v.eIr = eIr; v.eK = eK; v.eRw = eRw; v.ePc = ePc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [LANES*DATA_W-1:0] act,
                             input logic [LANES*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives payload k; ReadData is the inverse of ALUOut, MemtoReg is k bit 1.
  task automatic drivePayload(input logic iv, input logic orr, input logic fl,
                              input int k, input logic rw, input logic pc);
    logic [31:0] kv;
    kv        = 32'(k);
    in_valid  = iv;
    out_ready = orr;
    FLUSH     = fl;
    WA3M      = kv[REG_AW-1:0];
    ALUOutM   = makeAlu(k);
    ReadDataM = ~makeAlu(k);
    MemtoRegM = kv[1];
    RegWriteM = rw;
    PCSrcM    = pc;
  endtask

  task automatic applyStimulus(input vecT v);
    drivePayload(v.iv, v.orr, v.fl, v.k, v.rw, v.pc);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkState(input string tag, input logic eOv, input logic eIr,
                            input int eK, input logic eRw, input logic ePc);
    logic [31:0] kv;
    kv = 32'(eK);
    checkOutput({tag, " out_valid"}, 512'(out_valid), 512'(eOv));
    checkOutput({tag, " in_ready"},  512'(in_ready),  512'(eIr));
    checkOutput({tag, " WA3W"},      512'(WA3W),      512'(kv[REG_AW-1:0]));
    checkOutput({tag, " ALUOutW"},   ALUOutW,         makeAlu(eK));
    checkOutput({tag, " ReadDataW"}, ReadDataW,       ~makeAlu(eK));
    checkOutput({tag, " MemtoRegW"}, 512'(MemtoRegW), 512'(kv[1]));
    checkOutput({tag, " RegWriteW"}, 512'(RegWriteW), 512'(eRw));
    checkOutput({tag, " PCSrcW"},    512'(PCSrcW),    512'(ePc));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"}, 512'(out_valid), 512'(0));
    checkOutput({tag, " in_ready"},  512'(in_ready),  512'(1));
    checkOutput({tag, " RegWriteW"}, 512'(RegWriteW), 512'(0));
    checkOutput({tag, " PCSrcW"},    512'(PCSrcW),    512'(0));
    checkOutput({tag, " WA3W"},      512'(WA3W),      512'(0));
    checkOutput({tag, " ALUOutW"},   ALUOutW,         512'(0));
  endtask

  // Main test sequence.
  initial begin
    //                 iv orr fl  k  rw pc   eOv eIr eK eRw ePc
    // Streaming: one per cycle, one cycle latency.
    vecs[0]  = mkVec(1, 1, 0,  1, 1, 0,  1, 1,  1, 1, 0);
    vecs[1]  = mkVec(1, 1, 0,  2, 0, 0,  1, 1,  2, 0, 0);
    vecs[2]  = mkVec(1, 1, 0,  3, 1, 1,  1, 1,  3, 1, 1);
    vecs[3]  = mkVec(1, 1, 0,  4, 0, 0,  1, 1,  4, 0, 0);
    vecs[4]  = mkVec(1, 1, 0,  5, 1, 0,  1, 1,  5, 1, 0);
    vecs[5]  = mkVec(1, 1, 0,  6, 0, 0,  1, 1,  6, 0, 0);
    vecs[6]  = mkVec(1, 1, 0,  7, 1, 0,  1, 1,  7, 1, 0);
    vecs[7]  = mkVec(1, 1, 0,  8, 1, 1,  1, 1,  8, 1, 1);
    vecs[8]  = mkVec(0, 1, 0, 15, 1, 1,  0, 1,  8, 0, 0);
    // Backpressure: 3 and 4 accepted, 5 waits, then 3,4,5 drain in order.
    vecs[9]  = mkVec(1, 0, 0,  3, 1, 0,  1, 1,  3, 1, 0);
    vecs[10] = mkVec(1, 0, 0,  4, 1, 0,  1, 0,  3, 1, 0);
    vecs[11] = mkVec(1, 0, 0,  5, 1, 0,  1, 0,  3, 1, 0);
    vecs[12] = mkVec(1, 1, 0,  5, 1, 0,  1, 1,  4, 1, 0);
    vecs[13] = mkVec(1, 1, 0,  5, 1, 0,  1, 1,  5, 1, 0);
    vecs[14] = mkVec(0, 1, 0,  5, 1, 0,  0, 1,  5, 0, 0);
    // Flush while TWO with a payload (9) offered; 9 must never appear.
    vecs[15] = mkVec(1, 0, 0,  6, 1, 0,  1, 1,  6, 1, 0);
    vecs[16] = mkVec(1, 0, 0,  7, 1, 0,  1, 0,  6, 1, 0);
    vecs[17] = mkVec(1, 0, 1,  9, 1, 1,  0, 1,  6, 0, 0);
    vecs[18] = mkVec(0, 1, 0,  9, 1, 1,  0, 1,  6, 0, 0);
    // Flush in ONE with an accepted input and out_ready high: 11 discarded.
    vecs[19] = mkVec(1, 0, 0, 10, 1, 0,  1, 1, 10, 1, 0);
    vecs[20] = mkVec(1, 1, 1, 11, 1, 1,  0, 1, 10, 0, 0);
    vecs[21] = mkVec(0, 1, 0, 11, 1, 1,  0, 1, 10, 0, 0);
    vecs[22] = mkVec(1, 0, 0, 13, 1, 0,  1, 1, 13, 1, 0);
    vecs[23] = mkVec(0, 1, 0, 14, 1, 1,  0, 1, 13, 0, 0);
    // Gating: controls high exactly one cycle, data held in the bubble.
    vecs[24] = mkVec(1, 1, 0, 12, 1, 1,  1, 1, 12, 1, 1);
    vecs[25] = mkVec(0, 1, 0, 14, 1, 1,  0, 1, 12, 0, 0);

    RST_N = 1'b0;
    drivePayload(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    $display("[TB] reset state");
    checkResetState("reset");

    RST_N = 1'b1;
    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkState($sformatf("row%0d", i), vecs[i].eOv, vecs[i].eIr, vecs[i].eK,
                 vecs[i].eRw, vecs[i].ePc);
    end

    // Reset asserted between edges while TWO is held.
    $display("[TB] reset mid-stream");
    drivePayload(1, 0, 0, 1, 1, 1);
    tick();
    drivePayload(1, 0, 0, 2, 1, 0);
    tick();
    checkState("fillTwo", 1, 0, 1, 1, 1);
    #2;
    RST_N = 1'b0;
    #1;
    checkResetState("asyncReset");
    drivePayload(1, 1, 0, 3, 1, 1);
    repeat (2) tick();
    checkResetState("heldReset");
    RST_N = 1'b1;
    drivePayload(1, 0, 0, 4, 1, 0);
    tick();
    checkState("release", 1, 1, 4, 1, 0);

`ifdef MW_STALL_CNT_EN
    $display("[TB] stall counter");
    drivePayload(0, 0, 0, 5, 0, 0);
    repeat (5) tick();
    checkOutput("stallCnt5", 512'(stall_cnt), 512'(5));
    repeat (15) tick();
    checkOutput("stallCntSat", 512'(stall_cnt), 512'(15));
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checkOutput("stallCntFlush", 512'(stall_cnt), 512'(15));
    checkOutput("stallFlush out_valid", 512'(out_valid), 512'(0));
`else
    drivePayload(0, 1, 0, 5, 0, 0);
    tick();
    checkState("drain", 0, 1, 4, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
